// File: rtl/btn_pulse_gen.sv
// rtl/btn_pulse_gen.sv - push-button synchronizer, debouncer and press/release strobe generator
// Optional auto-repeat of btn_re while held: define BTN_AUTOREPEAT_EN.
module btn_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 1,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic clk,
    input  logic async_reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_re,
    output logic btn_fe,
    output logic busy
);

    localparam int MAX_DH = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_C  = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
    localparam int CW     = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] DB_LIM  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_CHK,
        PRESSED,
        RELEASE_CHK
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          pin;
    logic          sync_a;
    logic          sync;

    assign pin = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            sync_a <= 1'b0;
            sync   <= 1'b0;
        end else begin
            sync_a <= pin;
            sync   <= sync_a;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] REP_LIM  = CW'(REPEAT_CYCLES);
    logic [CW-1:0] rep;
    logic          repeating;
`endif

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            state     <= RELEASED;
            cnt       <= '0;
            btn_level <= 1'b0;
            btn_re    <= 1'b0;
            btn_fe    <= 1'b0;
            busy      <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rep       <= '0;
            repeating <= 1'b0;
`endif
        end else begin
            btn_re <= 1'b0;
            btn_fe <= 1'b0;
            case (state)
                RELEASED: begin
                    if (sync) begin
                        state <= PRESS_CHK;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end
                end
                PRESS_CHK: begin
                    if (!sync) begin
                        state <= RELEASED;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == DB_LIM) begin
                        state     <= PRESSED;
                        cnt       <= '0;
                        btn_level <= 1'b1;
                        btn_re    <= 1'b1;
                        busy      <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                        rep       <= '0;
                        repeating <= 1'b0;
`endif
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!sync) begin
                        state <= RELEASE_CHK;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end
`ifdef BTN_AUTOREPEAT_EN
                    // First pulse after HOLD_CYCLES, then one every REPEAT_CYCLES.
                    else if (rep + CNT_ONE == (repeating ? REP_LIM : HOLD_LIM)) begin
                        rep       <= '0;
                        repeating <= 1'b1;
                        btn_re    <= 1'b1;
                    end else if (rep != CNT_MAX) begin
                        rep <= rep + CNT_ONE;
                    end
`endif
                end
                RELEASE_CHK: begin
                    // The repeat counter is left untouched here so a bounce resumes it.
                    if (sync) begin
                        state <= PRESSED;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == DB_LIM) begin
                        state     <= RELEASED;
                        cnt       <= '0;
                        btn_level <= 1'b0;
                        btn_fe    <= 1'b1;
                        busy      <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                        rep       <= '0;
                        repeating <= 1'b0;
`endif
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= RELEASED;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_pulse_gen.sv
// tb/tb_btn_pulse_gen.sv - directed vector bench for btn_pulse_gen
module tb_btn_pulse_gen;

    localparam int D = 4;
    localparam int H = 20;
    localparam int R = 8;

    logic clk = 1'b0;
    logic async_reset;
    logic btn_raw;
    logic btn_level, btn_re, btn_fe, busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    btn_pulse_gen #(
        .DEBOUNCE_CYCLES(D),
        .ACTIVE_LOW     (1),
        .HOLD_CYCLES    (H),
        .REPEAT_CYCLES  (R)
    ) dut (
        .clk        (clk),
        .async_reset(async_reset),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_re     (btn_re),
        .btn_fe     (btn_fe),
        .busy       (busy)
    );

    typedef struct {
        string name;
        bit    raw;
        bit    lvl;
        bit    re;
        bit    fe;
        bit    bsy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string n, input bit raw, input bit lvl, input bit re,
                       input bit fe, input bit bsy);
        vec_t v;
        v.name = n; v.raw = raw; v.lvl = lvl; v.re = re; v.fe = fe; v.bsy = bsy;
        vecs.push_back(v);
    endtask

    int re_at[$];
    int fe_at[$];
    int exp_re[$];

    initial begin
        // Clean press: step n lands just after edge e0+n-1.
        add("press1", 0, 0, 0, 0, 0);
        add("press2", 0, 0, 0, 0, 0);
        add("press3", 0, 0, 0, 0, 1);
        add("press4", 0, 0, 0, 0, 1);
        add("press5", 0, 0, 0, 0, 1);
        add("press6", 0, 0, 0, 0, 1);
        add("press7", 0, 1, 1, 0, 0);
        add("press8", 0, 1, 0, 0, 0);
        add("press9", 0, 1, 0, 0, 0);
        // Clean release
        add("rel1", 1, 1, 0, 0, 0);
        add("rel2", 1, 1, 0, 0, 0);
        add("rel3", 1, 1, 0, 0, 1);
        add("rel4", 1, 1, 0, 0, 1);
        add("rel5", 1, 1, 0, 0, 1);
        add("rel6", 1, 1, 0, 0, 1);
        add("rel7", 1, 0, 0, 1, 0);
        add("rel8", 1, 0, 0, 0, 0);
        // Bounce: low 3, high 1, low 3, then high
        add("bnc1", 0, 0, 0, 0, 0);
        add("bnc2", 0, 0, 0, 0, 0);
        add("bnc3", 0, 0, 0, 0, 1);
        add("bnc4", 1, 0, 0, 0, 1);
        add("bnc5", 0, 0, 0, 0, 1);
        add("bnc6", 0, 0, 0, 0, 0);
        add("bnc7", 0, 0, 0, 0, 1);
        add("bnc8", 1, 0, 0, 0, 1);
        add("bnc9", 1, 0, 0, 0, 1);
        add("bnc10", 1, 0, 0, 0, 0);
        add("bnc11", 1, 0, 0, 0, 0);
        add("bnc12", 1, 0, 0, 0, 0);

        async_reset = 1'b1;
        btn_raw     = 1'b1;
        #2;
        check("reset_outputs", {btn_level, btn_re, btn_fe, busy}, 0);
        repeat (3) step();
        async_reset = 1'b0;

        for (int i = 0; i < 50; i++) begin
            step();
            check("idle_outputs", {btn_level, btn_re, btn_fe, busy}, 0);
        end

        foreach (vecs[i]) begin
            btn_raw = vecs[i].raw;
            step();
            check({vecs[i].name, "_level"}, btn_level, vecs[i].lvl);
            check({vecs[i].name, "_re"}, btn_re, vecs[i].re);
            check({vecs[i].name, "_fe"}, btn_fe, vecs[i].fe);
            check({vecs[i].name, "_busy"}, busy, vecs[i].bsy);
        end

        // Reset while a press is being qualified, key kept down.
        btn_raw = 1'b0;
        repeat (4) step();
        check("midq_busy_before", busy, 1);
        async_reset = 1'b1;
        #1;
        check("midq_reset_outputs", {btn_level, btn_re, btn_fe, busy}, 0);
        @(posedge clk);
        #1;
        async_reset = 1'b0;

        // Hold, then release at step 65; acceptance expected at step 7.
        for (int i = 1; i <= 74; i++) begin
            if (i == 65) btn_raw = 1'b1;
            step();
            if (btn_re) re_at.push_back(i);
            if (btn_fe) fe_at.push_back(i);
            if (btn_re && btn_fe) check("re_fe_exclusive", 1, 0);
            if (i == 70) check("held_level", btn_level, 1);
            if (i == 71) check("released_level", btn_level, 0);
        end

        exp_re.push_back(7);
`ifdef BTN_AUTOREPEAT_EN
        exp_re.push_back(7 + H);
        exp_re.push_back(7 + H + R);
        exp_re.push_back(7 + H + 2 * R);
        exp_re.push_back(7 + H + 3 * R);
        exp_re.push_back(7 + H + 4 * R);
`endif
        check("re_pulse_count", re_at.size(), exp_re.size());
        foreach (exp_re[k]) begin
            check($sformatf("re_pulse_step%0d", k), (k < re_at.size()) ? re_at[k] : -1, exp_re[k]);
        end
        check("fe_pulse_count", fe_at.size(), 1);
        check("fe_pulse_step", (fe_at.size() > 0) ? fe_at[0] : -1, 71);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
